// File: rtl/minmax_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : minmax_sort_ctrl
// Purpose  : N-entry sequential sorter. A single unsigned min/max
//            compare-exchange unit is time-shared over a register array. The
//            block loads N words, runs a fixed-length bubble sort (one
//            compare-exchange per cycle), then streams the words out in
//            ascending order.
// Ports    : clk, rst (async, active-high)
//            in_valid/in_ready/in_data    - load side, ready only in LOAD
//            out_valid/out_ready/out_data - drain side, valid only in DRAIN
//            busy                         - high while sorting
// Revision : 1.0 - initial release
// ============================================================================
module minmax_sort_ctrl #(
  parameter int W = 6,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SORT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Explicit N-1 / N-2 terminal counts keep non-power-of-2 N correct.
  localparam logic [CW-1:0] c_LAST      = CW'(N - 1);
  localparam logic [CW-1:0] c_PAIR_LAST = CW'(N - 2);

  logic [1:0]    r_state;
  logic [W-1:0]  r_mem [N];
  logic [CW-1:0] r_wr_idx;
  logic [CW-1:0] r_rd_idx;
  logic [CW-1:0] r_i;
  logic [CW-1:0] r_p;

  logic [CW-1:0] w_i_nxt;
  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_swap;

  // Shared compare-exchange unit working on the pair (i, i+1).
  assign w_i_nxt = r_i + 1'b1;
  assign w_a     = r_mem[r_i];
  assign w_b     = r_mem[w_i_nxt];
  assign w_swap  = (w_a > w_b);  // equal values stay put

  assign in_ready  = (r_state == S_LOAD);
  assign busy      = (r_state == S_SORT);
  assign out_valid = (r_state == S_DRAIN);
  assign out_data  = (r_state == S_DRAIN) ? r_mem[r_rd_idx] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_LOAD;
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_i      <= '0;
      r_p      <= '0;
      for (int k = 0; k < N; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_mem[r_wr_idx] <= in_data;
            if (r_wr_idx == c_LAST) begin
              r_wr_idx <= '0;
              r_i      <= '0;
              r_p      <= '0;
              r_state  <= S_SORT;
            end else begin
              r_wr_idx <= r_wr_idx + 1'b1;
            end
          end
        end

        S_SORT: begin
          if (w_swap) begin
            r_mem[r_i]    <= w_b;
            r_mem[w_i_nxt] <= w_a;
          end
          // Fixed (N-1) passes of (N-1) pairs; no early exit so the
          // latency is data-independent.
          if (r_i == c_PAIR_LAST) begin
            r_i <= '0;
            if (r_p == c_PAIR_LAST) begin
              r_p      <= '0;
              r_rd_idx <= '0;
              r_state  <= S_DRAIN;
            end else begin
              r_p <= r_p + 1'b1;
            end
          end else begin
            r_i <= w_i_nxt;
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            if (r_rd_idx == c_LAST) begin
              r_rd_idx <= '0;
              r_state  <= S_LOAD;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
            end
          end
        end

        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_minmax_sort_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_minmax_sort_ctrl
// Purpose  : Directed bench for minmax_sort_ctrl. Two instances (N=4, N=8,
//            W=6) share the stimulus; r_sel picks which one is driven and
//            observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_minmax_sort_ctrl;

  logic       clk;
  logic       rst;
  logic       r_sel;       // 0: N=4 instance, 1: N=8 instance
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_ready;

  logic       w_rdy4, w_ov4, w_busy4;
  logic       w_rdy8, w_ov8, w_busy8;
  logic [5:0] w_od4, w_od8;

  logic       w_in_ready, w_out_valid, w_busy;
  logic [5:0] w_out_data;

  int checks;
  int errors;

  minmax_sort_ctrl #(.W(6), .N(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~r_sel),
    .in_ready  (w_rdy4),
    .in_data   (in_data),
    .out_valid (w_ov4),
    .out_ready (out_ready & ~r_sel),
    .out_data  (w_od4),
    .busy      (w_busy4)
  );

  minmax_sort_ctrl #(.W(6), .N(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & r_sel),
    .in_ready  (w_rdy8),
    .in_data   (in_data),
    .out_valid (w_ov8),
    .out_ready (out_ready & r_sel),
    .out_data  (w_od8),
    .busy      (w_busy8)
  );

  assign w_in_ready  = r_sel ? w_rdy8  : w_rdy4;
  assign w_out_valid = r_sel ? w_ov8   : w_ov4;
  assign w_busy      = r_sel ? w_busy8 : w_busy4;
  assign w_out_data  = r_sel ? w_od8   : w_od4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the last accept.
  task automatic load_words(input int n, input int v[8], input int gap);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = 6'(v[k]);
      chk("in_ready_load", 32'(w_in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if (gap > 0 && k < n - 1) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          chk("busy_in_gap", 32'(w_busy), 32'd0);
          @(negedge clk);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_sort(input int exp_cycles, input bit junk);
    int cnt;
    cnt = 0;
    while (w_busy === 1'b1 && cnt < 200) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 6'd42;
        chk("in_ready_sort", 32'(w_in_ready), 32'd0);
      end
      cnt++;
      @(negedge clk);
    end
    chk("sort_cycles", 32'(cnt), 32'(exp_cycles));
    chk("out_valid_after_sort", 32'(w_out_valid), 32'd1);
  endtask

  task automatic drain(input int n, input int e[8], input bit toggle, input bit junk);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 100) begin
      chk("out_valid", 32'(w_out_valid), 32'd1);
      chk("out_data", 32'(w_out_data), 32'(e[k]));
      if (junk) chk("in_ready_drain", 32'(w_in_ready), 32'd0);
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (out_ready) k++;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("drain_count", 32'(k), 32'(n));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("in_ready_after_drain", 32'(w_in_ready), 32'd1);
    chk("out_valid_after_drain", 32'(w_out_valid), 32'd0);
  endtask

  task automatic run_batch(input bit sel, input int n, input int v[8], input int e[8],
                           input int gap, input bit junk, input bit toggle);
    r_sel = sel;
    load_words(n, v, gap);
    wait_sort((n - 1) * (n - 1), junk);
    drain(n, e, toggle, junk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    r_sel     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    #12;
    chk("rst_in_ready", 32'(w_in_ready), 32'd1);
    chk("rst_out_valid", 32'(w_out_valid), 32'd0);
    chk("rst_busy", 32'(w_busy), 32'd0);
    chk("rst_out_data", 32'(w_out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic sort, N=4
    run_batch(1'b0, 4, '{5,3,7,1,0,0,0,0}, '{1,3,5,7,0,0,0,0}, 0, 1'b0, 1'b0);

    // Extremes and duplicates, N=8
    run_batch(1'b1, 8, '{63,0,63,0,17,17,1,62}, '{0,0,1,17,17,62,63,63}, 0, 1'b0, 1'b0);
    // Pre-sorted and reversed, N=8
    run_batch(1'b1, 8, '{0,1,2,3,4,5,6,7}, '{0,1,2,3,4,5,6,7}, 0, 1'b0, 1'b0);
    run_batch(1'b1, 8, '{7,6,5,4,3,2,1,0}, '{0,1,2,3,4,5,6,7}, 0, 1'b0, 1'b0);

    // Output backpressure, N=4
    run_batch(1'b0, 4, '{9,2,4,8,0,0,0,0}, '{2,4,8,9,0,0,0,0}, 0, 1'b0, 1'b1);

    // Input gaps plus ignored 42 during SORT/DRAIN, N=4
    run_batch(1'b0, 4, '{6,1,5,3,0,0,0,0}, '{1,3,5,6,0,0,0,0}, 2, 1'b1, 1'b0);

    // Reset three cycles into SORT
    r_sel = 1'b0;
    load_words(4, '{9,8,7,6,0,0,0,0}, 0);
    repeat (3) @(negedge clk);
    chk("busy_before_rst", 32'(w_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(w_in_ready), 32'd1);
    chk("midrst_busy", 32'(w_busy), 32'd0);
    chk("midrst_out_valid", 32'(w_out_valid), 32'd0);
    chk("midrst_out_data", 32'(w_out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_batch(1'b0, 4, '{4,4,1,2,0,0,0,0}, '{1,2,4,4,0,0,0,0}, 0, 1'b0, 1'b0);

    // Back-to-back batches
    run_batch(1'b0, 4, '{3,2,1,0,0,0,0,0}, '{0,1,2,3,0,0,0,0}, 0, 1'b0, 1'b0);
    run_batch(1'b0, 4, '{10,30,20,40,0,0,0,0}, '{10,20,30,40,0,0,0,0}, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
